// File: rtl/play_ctrl.sv
// Playback controller and source arbiter for the electronic-organ datapath.
// It sequences the auto-play table and arbitrates live keys against playback.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | nothing playing, output rest
// ST_AUTO   | auto-play running, beat divider advancing
// ST_PAUSE  | auto-play frozen mid-beat, output rest
// ST_MANUAL | live key owns the tone generator, auto-play frozen
module play_ctrl #(
    parameter int unsigned BASE_DIV = 12500000,
    parameter int unsigned GAP_CYC  = 1250000,
    parameter int unsigned SONG_LEN = 43,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    input  logic [1:0] tempo_sel,
    input  logic       key_valid,
    input  logic [2:0] key_note,
    input  logic [1:0] key_oct,
    input  logic [2:0] auto_note,
    input  logic [1:0] auto_oct,
    output logic       beat_en,
    output logic       auto_rst,
    output logic [2:0] note_out,
    output logic [1:0] oct_out,
    output logic [1:0] mode,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_AUTO   = 2'b01;
    localparam logic [1:0] ST_PAUSE  = 2'b10;
    localparam logic [1:0] ST_MANUAL = 2'b11;

    localparam int BCW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [23:0]    BASE      = 24'(BASE_DIV);
    localparam logic [24:0]    GAP       = 25'(GAP_CYC);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(SONG_LEN - 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYC - 1);
    localparam logic [2:0]     NOTE_REST = 3'b111;
    localparam logic [1:0]     OCT_MUTE  = 2'b00;

    logic [1:0]     state, state_nxt;
    logic [1:0]     ret_state, ret_nxt;
    logic [23:0]    div_cnt, div_nxt;
    logic [23:0]    period, period_nxt;
    logic [23:0]    period_sel;
    logic [BCW-1:0] beat_cnt, beat_nxt;
    logic [HCW-1:0] rel_cnt, rel_nxt;
    logic           beat_en_nxt;
    logic           auto_rst_nxt;
    logic           song_end, song_end_nxt;
    logic           in_gap;
    logic [2:0]     note_nxt;
    logic [1:0]     oct_nxt;

    assign period_sel = BASE >> tempo_sel;

    always_comb begin
        state_nxt    = state;
        ret_nxt      = ret_state;
        div_nxt      = div_cnt;
        period_nxt   = period;
        beat_nxt     = beat_cnt;
        rel_nxt      = rel_cnt;
        beat_en_nxt  = 1'b0;
        // A song that ran out on its last beat rewinds the source one cycle later.
        auto_rst_nxt = song_end;
        song_end_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    state_nxt = ST_MANUAL;
                    ret_nxt   = ST_IDLE;
                    rel_nxt   = HOLD_LOAD;
                end else if (start) begin
                    state_nxt    = ST_AUTO;
                    div_nxt      = 24'd0;
                    beat_nxt     = '0;
                    period_nxt   = period_sel;
                    auto_rst_nxt = 1'b1;
                end
            end

            ST_AUTO: begin
                if (stop) begin
                    state_nxt    = ST_IDLE;
                    auto_rst_nxt = 1'b1;
                end else if (key_valid) begin
                    state_nxt = ST_MANUAL;
                    ret_nxt   = ST_AUTO;
                    rel_nxt   = HOLD_LOAD;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else if (div_cnt == period - 24'd1) begin
                    beat_en_nxt = 1'b1;
                    div_nxt     = 24'd0;
                    period_nxt  = period_sel;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_nxt = '0;
                        if (!loop) begin
                            state_nxt    = ST_IDLE;
                            song_end_nxt = 1'b1;
                        end
                    end else begin
                        beat_nxt = beat_cnt + BCW'(1);
                    end
                end else begin
                    div_nxt = div_cnt + 24'd1;
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_nxt    = ST_IDLE;
                    auto_rst_nxt = 1'b1;
                end else if (key_valid) begin
                    state_nxt = ST_MANUAL;
                    ret_nxt   = ST_PAUSE;
                    rel_nxt   = HOLD_LOAD;
                end else if (pause) begin
                    state_nxt = ST_AUTO;
                end
            end

            ST_MANUAL: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    if (ret_state != ST_IDLE) begin
                        auto_rst_nxt = 1'b1;
                    end
                end else if (key_valid) begin
                    rel_nxt = HOLD_LOAD;
                end else if (rel_cnt == '0) begin
                    state_nxt = ret_state;
                end else begin
                    rel_nxt = rel_cnt - HCW'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The mux looks at next-state values so note_out lines up with mode and div_cnt.
    always_comb begin
        note_nxt = NOTE_REST;
        oct_nxt  = OCT_MUTE;
        in_gap   = (GAP_CYC != 0) && (({1'b0, div_nxt} + GAP) >= {1'b0, period_nxt});

        case (state_nxt)
            ST_MANUAL: begin
                if (key_valid) begin
                    note_nxt = key_note;
                    oct_nxt  = key_oct;
                end
            end
            ST_AUTO: begin
                if (!in_gap) begin
                    note_nxt = auto_note;
                    oct_nxt  = auto_oct;
                end
            end
            default: begin
                note_nxt = NOTE_REST;
                oct_nxt  = OCT_MUTE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            div_cnt   <= 24'd0;
            period    <= BASE;
            beat_cnt  <= '0;
            rel_cnt   <= HOLD_LOAD;
            beat_en   <= 1'b0;
            auto_rst  <= 1'b0;
            song_end  <= 1'b0;
            note_out  <= NOTE_REST;
            oct_out   <= OCT_MUTE;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            div_cnt   <= div_nxt;
            period    <= period_nxt;
            beat_cnt  <= beat_nxt;
            rel_cnt   <= rel_nxt;
            beat_en   <= beat_en_nxt;
            auto_rst  <= auto_rst_nxt;
            song_end  <= song_end_nxt;
            note_out  <= note_nxt;
            oct_out   <= oct_nxt;
        end
    end

    assign mode = state;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl with a short beat period (16 cycles, 2-cycle gap).
// A small beat model tracks divider position, period and beat count for AUTO stretches.
module tb_play_ctrl;

    localparam int BASE = 16;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop;
    logic [1:0] tempo_sel;
    logic       key_valid;
    logic [2:0] key_note;
    logic [1:0] key_oct;
    logic [2:0] auto_note;
    logic [1:0] auto_oct;
    logic       beat_en;
    logic       auto_rst;
    logic [2:0] note_out;
    logic [1:0] oct_out;
    logic [1:0] mode;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int exp_d;
    int exp_per;
    int exp_bc;
    bit song_done;
    bit wrapped;

    play_ctrl #(
        .BASE_DIV(16),
        .GAP_CYC (2),
        .SONG_LEN(43),
        .HOLD_CYC(4)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .tempo_sel(tempo_sel),
        .key_valid(key_valid),
        .key_note (key_note),
        .key_oct  (key_oct),
        .auto_note(auto_note),
        .auto_oct (auto_oct),
        .beat_en  (beat_en),
        .auto_rst (auto_rst),
        .note_out (note_out),
        .oct_out  (oct_out),
        .mode     (mode),
        .busy     (busy)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] m, input logic be,
                             input logic ar, input logic [2:0] n, input logic [1:0] o);
        chk({tag, ".mode"},     32'(mode),     32'(m));
        chk({tag, ".busy"},     32'(busy),     32'(m != 2'b00));
        chk({tag, ".beat_en"},  32'(beat_en),  32'(be));
        chk({tag, ".auto_rst"}, 32'(auto_rst), 32'(ar));
        chk({tag, ".note"},     32'(note_out), 32'(n));
        chk({tag, ".oct"},      32'(oct_out),  32'(o));
    endtask

    task automatic begin_auto(input string tag);
        start = 1'b1;
        tick();
        start   = 1'b0;
        exp_d   = 0;
        exp_per = BASE >> tempo_sel;
        exp_bc  = 0;
        check_out(tag, 2'b01, 1'b0, 1'b1, auto_note, auto_oct);
    endtask

    // One undisturbed AUTO cycle: advance the model, clock once, compare.
    task automatic auto_cycle(input string tag);
        logic [1:0] m_exp;
        logic       be_exp;
        m_exp     = 2'b01;
        be_exp    = 1'b0;
        song_done = 1'b0;
        wrapped   = 1'b0;
        if (exp_d == exp_per - 1) begin
            be_exp  = 1'b1;
            exp_d   = 0;
            exp_per = BASE >> tempo_sel;
            if (exp_bc == 42) begin
                exp_bc  = 0;
                wrapped = 1'b1;
                if (!loop) begin
                    m_exp     = 2'b00;
                    song_done = 1'b1;
                end
            end else begin
                exp_bc++;
            end
        end else begin
            exp_d++;
        end
        tick();
        if (m_exp == 2'b00)
            check_out(tag, 2'b00, 1'b1, 1'b0, 3'b111, 2'b00);
        else if (exp_d + 2 >= exp_per)
            check_out(tag, 2'b01, be_exp, 1'b0, 3'b111, 2'b00);
        else
            check_out(tag, 2'b01, be_exp, 1'b0, auto_note, auto_oct);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        stop      = 1'b0;
        pause     = 1'b0;
        loop      = 1'b0;
        tempo_sel = 2'd0;
        key_valid = 1'b0;
        key_note  = 3'b000;
        key_oct   = 2'b00;
        auto_note = 3'b101;
        auto_oct  = 2'b01;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_out("idle_after_reset", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);

        // Start at tempo 0: two full 16-cycle beats
        begin_auto("start");
        for (int i = 0; i < 15; i++) auto_cycle("beat1_run");
        auto_cycle("beat1_edge");
        chk("first_beat_at_16", 32'(beat_en), 32'd1);
        for (int i = 0; i < 16; i++) auto_cycle("beat2_run");

        // Tempo change mid-beat with a different source note
        auto_note = 3'b011;
        auto_oct  = 2'b11;
        for (int i = 0; i < 5; i++) auto_cycle("pre_tempo");
        tempo_sel = 2'd2;
        for (int i = 0; i < 10; i++) auto_cycle("tempo_cur_beat");
        auto_cycle("tempo_cur_end");
        chk("tempo_beat_still_16", 32'(beat_en), 32'd1);
        for (int i = 0; i < 3; i++) auto_cycle("fast_beat");
        auto_cycle("fast_beat_end");
        chk("fast_beat_4cyc", 32'(beat_en), 32'd1);
        tempo_sel = 2'd0;
        for (int i = 0; i < 4; i++) auto_cycle("fast_beat_last");
        chk("fast_beat_last_end", 32'(beat_en), 32'd1);

        // Key preempt at div_cnt=7, with a re-press during the release hold
        auto_note = 3'b101;
        auto_oct  = 2'b01;
        for (int i = 0; i < 7; i++) auto_cycle("pre_key");
        key_valid = 1'b1;
        key_note  = 3'b010;
        key_oct   = 2'b10;
        tick();
        check_out("key_enter", 2'b11, 1'b0, 1'b0, 3'b010, 2'b10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out("key_held", 2'b11, 1'b0, 1'b0, 3'b010, 2'b10);
        end
        key_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("key_release_a", 2'b11, 1'b0, 1'b0, 3'b111, 2'b00);
        end
        key_valid = 1'b1;
        tick();
        check_out("key_repress", 2'b11, 1'b0, 1'b0, 3'b010, 2'b10);
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("key_release_b", 2'b11, 1'b0, 1'b0, 3'b111, 2'b00);
        end
        tick();
        check_out("key_return_auto", 2'b01, 1'b0, 1'b0, 3'b101, 2'b01);
        for (int i = 0; i < 8; i++) auto_cycle("key_resume");
        auto_cycle("key_resume_end");
        chk("key_resume_beat_9", 32'(beat_en), 32'd1);

        // Start ignored in AUTO, then pause twice
        start = 1'b1;
        auto_cycle("start_ignored");
        start = 1'b0;
        for (int i = 0; i < 2; i++) auto_cycle("pre_pause");
        pause = 1'b1;
        tick();
        pause = 1'b0;
        check_out("pause_enter", 2'b10, 1'b0, 1'b0, 3'b111, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("paused", 2'b10, 1'b0, 1'b0, 3'b111, 2'b00);
        end
        pause = 1'b1;
        tick();
        pause = 1'b0;
        check_out("pause_resume", 2'b01, 1'b0, 1'b0, 3'b101, 2'b01);
        for (int i = 0; i < 12; i++) auto_cycle("pause_remaining");
        auto_cycle("pause_remaining_end");
        chk("pause_beat_after_13", 32'(beat_en), 32'd1);

        // loop=1: song wraps and keeps playing
        loop    = 1'b1;
        wrapped = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            auto_cycle("loop_run");
            if (wrapped) break;
        end
        chk("loop_wrap_seen", 32'(wrapped), 32'd1);
        for (int i = 0; i < 16; i++) auto_cycle("loop_after_wrap");

        // loop=0: the 43rd beat ends the song
        loop      = 1'b0;
        song_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            auto_cycle("song_run");
            if (song_done) break;
        end
        chk("song_end_seen", 32'(song_done), 32'd1);
        tick();
        check_out("song_end_auto_rst", 2'b00, 1'b0, 1'b1, 3'b111, 2'b00);
        tick();
        check_out("song_end_idle", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);

        // stop and key_valid together in AUTO: stop wins
        begin_auto("restart");
        for (int i = 0; i < 3; i++) auto_cycle("pre_stop");
        stop      = 1'b1;
        key_valid = 1'b1;
        tick();
        stop      = 1'b0;
        key_valid = 1'b0;
        check_out("stop_beats_key", 2'b00, 1'b0, 1'b1, 3'b111, 2'b00);
        tick();
        check_out("stop_settled", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);

        // Manual from IDLE returns to IDLE without rewinding the source
        key_valid = 1'b1;
        key_note  = 3'b110;
        key_oct   = 2'b01;
        tick();
        check_out("idle_key", 2'b11, 1'b0, 1'b0, 3'b110, 2'b01);
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("idle_key_release", 2'b11, 1'b0, 1'b0, 3'b111, 2'b00);
        end
        tick();
        check_out("idle_key_back", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        stop      = 1'b1;
        tick();
        stop      = 1'b0;
        check_out("manual_stop_from_idle", 2'b00, 1'b0, 1'b0, 3'b111, 2'b00);

        // Stop from PAUSE rewinds the source
        begin_auto("restart2");
        pause = 1'b1;
        tick();
        pause = 1'b0;
        check_out("pause2", 2'b10, 1'b0, 1'b0, 3'b111, 2'b00);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_out("pause_stop", 2'b00, 1'b0, 1'b1, 3'b111, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
